bcd_serial_adder: RTL and testbench

Digit-serial packed-BCD adder; the additive counterpart of the team's parallel BCD subtractor in the ALU datapath.
- Accepts two DIGITS-digit packed-BCD operands plus carry-in over a valid/ready handshake.
- Adds one decimal digit per clock, LSD first, with decimal (+6) correction.
- Returns the BCD sum, decimal carry-out and an invalid-digit flag over a second valid/ready handshake.
- Trades latency for area against the ripple-parallel arithmetic units.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_adder.sv | 27 ++
 rtl/bcd_serial_adder.sv | 151 +++++++++++++++
 tb/tb_bcd_serial_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared packed-BCD types, constants and helpers for the serial adder and
// the parallel BCD arithmetic units.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_ser_state_t;

  function automatic logic is_bcd_digit(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit decimal adder: binary add followed by +6 correction when the
// binary sum leaves the 0..9 range.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co
);

  logic [4:0] t_s;

  // binary digit sum and decimal correction
  always_comb begin
    t_s = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    if (t_s > {1'b0, BCD_MAX}) begin
      s  = t_s[3:0] + BCD_CORR;
      co = 1'b1;
    end else begin
      s  = t_s[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, LSD first, one digit per clock.
// Define BCD_SERIAL_SUB_EN to add the op port for ten's-complement subtraction.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 4 * DIGITS
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef BCD_SERIAL_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             invalid
);

  localparam int CW = $clog2(DIGITS + 1);

  function automatic logic any_invalid(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | ~is_bcd_digit(p[4*i +: 4]) | ~is_bcd_digit(q[4*i +: 4]);
    end
    return bad;
  endfunction

`ifdef BCD_SERIAL_SUB_EN
  function automatic logic [WIDTH-1:0] nines_comp(input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = BCD_MAX - q[4*i +: 4];
    end
    return r;
  endfunction
`endif

  bcd_ser_state_t   state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             invalid_r;

  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;
  bcd_digit_t       dig_s;
  logic             co_s;

  // operand B / carry-in as loaded: subtraction swaps in nines' complement and forces carry
  always_comb begin
    b_load_s = y;
    c_load_s = cin;
`ifdef BCD_SERIAL_SUB_EN
    if (op) begin
      b_load_s = nines_comp(y);
      c_load_s = 1'b1;
    end else begin
      b_load_s = y;
      c_load_s = cin;
    end
`endif
  end

  bcd_digit_adder u_digit (
    .a  (a_r[3:0]),
    .b  (b_r[3:0]),
    .ci (carry_r),
    .s  (dig_s),
    .co (co_s)
  );

  // control FSM and datapath registers; operands shift right so the current digit is always at [3:0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      invalid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= x;
            b_r        <= b_load_s;
            carry_r    <= c_load_s;
            invalid_r  <= any_invalid(x, y);
            sum_r      <= '0;
            cout_r     <= 1'b0;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_r == CW'(i)) sum_r[4*i +: 4] <= dig_s;
          end
          a_r     <= a_r >> 4;
          b_r     <= b_r >> 4;
          carry_r <= co_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(DIGITS - 1)) begin
            cout_r      <= co_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign invalid   = invalid_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=8): directed vectors, random
// BCD operands, backpressure, mid-run reset and, with BCD_SERIAL_SUB_EN, subtraction.
module tb_bcd_serial_adder;

  localparam int DIGITS = 8;
  localparam int W      = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         i;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         invalid;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
`ifdef BCD_SERIAL_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference decimal adder on packed BCD
  function automatic exp_t model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    int   t;
    int   cc;
    cc  = int'(c);
    e.i = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      t = int'(a[4*k +: 4]) + int'(b[4*k +: 4]) + cc;
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) e.i = 1'b1;
      if (t > 9) begin
        e.s[4*k +: 4] = 4'((t + 6) % 16);
        cc = 1;
      end else begin
        e.s[4*k +: 4] = 4'(t);
        cc = 0;
      end
    end
    e.c = 1'(cc);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int k = 0; k < DIGITS; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // one transaction: accept, latency check, optional backpressure/noise, scoreboard compare
  task automatic run_txn(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic cv,
                         input logic opv, input exp_t e, input int hold, input logic noisy);
    int   n;
    exp_t got;
    logic [W-1:0] held_sum;
    logic held_cout;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
    x = xv; y = yv; cin = cv; op = opv; in_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (noisy) begin
      x = 32'h55555555; y = 32'h44444444; cin = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    check_eq("in_ready_after_accept", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("latency", 64'(n), 64'(DIGITS));
    held_sum  = sum;
    held_cout = cout;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_sum", 64'(sum), 64'(held_sum));
      check_eq("hold_cout", 64'(cout), 64'(held_cout));
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = sb_q.pop_front();
      check_eq("sum", 64'(sum), 64'(got.s));
      check_eq("cout", 64'(cout), 64'(got.c));
      check_eq("invalid", 64'(invalid), 64'(got.i));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("done_to_idle_valid", 64'(out_valid), 64'd0);
    check_eq("done_to_idle_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; cin = 1'b0; op = 1'b0;
    #12;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_cout_inv", 64'({cout, invalid}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    e = '{s: 32'h99999999, c: 1'b0, i: 1'b0};
    run_txn(32'h12345678, 32'h87654321, 1'b0, 1'b0, e, 0, 1'b0);
    e = '{s: 32'h00000000, c: 1'b1, i: 1'b0};
    run_txn(32'h99999999, 32'h00000001, 1'b0, 1'b0, e, 5, 1'b1);
    e = '{s: 32'h00000001, c: 1'b0, i: 1'b0};
    run_txn(32'h0, 32'h0, 1'b1, 1'b0, e, 0, 1'b0);
    e = '{s: 32'h00000125, c: 1'b0, i: 1'b0};
    run_txn(32'h00000058, 32'h00000067, 1'b0, 1'b0, e, 0, 1'b0);
    e = '{s: 32'h00000010, c: 1'b0, i: 1'b1};
    run_txn(32'h0000000A, 32'h0, 1'b0, 1'b0, e, 0, 1'b0);
    e = '{s: 32'h00000003, c: 1'b0, i: 1'b0};
    run_txn(32'h00000001, 32'h00000002, 1'b0, 1'b0, e, 2, 1'b0);

    for (int r = 0; r < 6; r++) begin
      ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom_range(0, 1));
      run_txn(ra, rb, rc, 1'b0, model_add(ra, rb, rc), r % 3, 1'b0);
    end

    // reset while RUN is at digit counter 3
    @(negedge clk);
    x = 32'h11111111; y = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check_eq("midrun_rst_sum", 64'(sum), 64'd0);
    check_eq("midrun_rst_valid", 64'(out_valid), 64'd0);
    check_eq("midrun_rst_ready", 64'(in_ready), 64'd1);
    check_eq("midrun_rst_cout_inv", 64'({cout, invalid}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    e = '{s: 32'h33333333, c: 1'b0, i: 1'b0};
    run_txn(32'h11111111, 32'h22222222, 1'b0, 1'b0, e, 0, 1'b0);

`ifdef BCD_SERIAL_SUB_EN
    e = '{s: 32'h99999998, c: 1'b0, i: 1'b0};
    run_txn(32'h00000005, 32'h00000007, 1'b0, 1'b1, e, 0, 1'b0);
    e = '{s: 32'h00000002, c: 1'b1, i: 1'b0};
    run_txn(32'h00000007, 32'h00000005, 1'b0, 1'b1, e, 0, 1'b0);
`endif

    check_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
